// File: rtl/truth_table_pkg.sv
// Shared types and constants for the truth-table sequencer.
//   seq_state_t           : sequencer state encoding
//   VEC_IDX_W / VEC_COUNT : width of the vector index and number of vectors
//   SETTLE_CYCLES_DEFAULT : default hold time per vector, in clk cycles
//   timer_width()         : counter width needed for a given settle length
package truth_table_pkg;

    localparam int VEC_IDX_W             = 3;
    localparam int VEC_COUNT             = 8;
    localparam int SETTLE_CYCLES_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        DONE   = 2'd2
    } seq_state_t;

    // Counter only has to reach cycles-1; keep at least one bit so
    // SETTLE_CYCLES=1 still yields a legal vector.
    function automatic int timer_width(input int cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/settle_timer.sv
// Per-vector settle counter.
//   clk, rst_n : clock, async active-low reset
//   load       : clear the count (start of a sweep)
//   tick       : advance the count by one; wraps to 0 after the last cycle
//   last       : count is at SETTLE_CYCLES-1, i.e. this is the sampling cycle
module settle_timer
    import truth_table_pkg::*;
#(
    parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic tick,
    output logic last
);

    localparam int               CNT_W    = timer_width(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= '0;
        end else if (tick) begin
            count <= last ? '0 : count + 1'b1;
        end
    end

    assign last = (count == CNT_LAST);

endmodule

// File: rtl/truth_table_sequencer.sv
// Sweeps a 3-input logic cell through all 8 input vectors, holds each for
// SETTLE_CYCLES cycles, samples the cell output on the last cycle of each
// hold and compares the collected truth table with a latched expectation.
//   clk, rst_n         : clock, async active-low reset
//   start, abort       : begin a sweep (IDLE only) / cancel a running sweep
//   expected[7:0]      : expected truth table, latched when a sweep starts
//   in1, in2, in3      : cell inputs, vector index bits [2], [1], [0]
//   cell_out           : cell output
//   busy, done         : sweep running / one-cycle completion pulse
//   pass               : last completed sweep matched
//   observed, mismatch : sampled table, and its XOR with the latched table
//
// state  | meaning
// IDLE   | cell inputs parked at 000, waiting for start
// SETTLE | presenting vector idx, sampling it on the last settle cycle
// DONE   | one-cycle completion pulse, pass valid
module truth_table_sequencer
    import truth_table_pkg::*;
#(
    parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [VEC_COUNT-1:0] expected,
    output logic                 in1,
    output logic                 in2,
    output logic                 in3,
    input  logic                 cell_out,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [VEC_COUNT-1:0] observed,
    output logic [VEC_COUNT-1:0] mismatch
);

    localparam logic [VEC_IDX_W-1:0] IDX_LAST = VEC_IDX_W'(VEC_COUNT - 1);

    seq_state_t           state;
    seq_state_t           state_nxt;
    logic [VEC_IDX_W-1:0] idx;
    logic [VEC_COUNT-1:0] exp_lat;
    logic [VEC_COUNT-1:0] observed_nxt;
    logic                 accept;
    logic                 sample;
    logic                 timer_last;

    settle_timer #(
        .SETTLE_CYCLES(SETTLE_CYCLES)
    ) u_settle_timer (
        .clk  (clk),
        .rst_n(rst_n),
        .load (accept),
        .tick (state == SETTLE),
        .last (timer_last)
    );

    // Abort takes priority over both a new start and a pending sample, so
    // an aborted sweep never records the vector it was cancelled on.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        sample    = 1'b0;
        case (state)
            IDLE: begin
                if (start && !abort) begin
                    accept    = 1'b1;
                    state_nxt = SETTLE;
                end
            end
            SETTLE: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (timer_last) begin
                    sample = 1'b1;
                    if (idx == IDX_LAST) begin
                        state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_comb begin
        observed_nxt      = observed;
        observed_nxt[idx] = cell_out;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            idx      <= '0;
            exp_lat  <= '0;
            observed <= '0;
            pass     <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                exp_lat  <= expected;
                observed <= '0;
                pass     <= 1'b0;
                idx      <= '0;
            end else if (sample) begin
                observed <= observed_nxt;
                // Compare against the table including the final sample, so
                // pass is already valid during the DONE cycle.
                if (idx == IDX_LAST) begin
                    pass <= (observed_nxt == exp_lat);
                end else begin
                    idx <= idx + 1'b1;
                end
            end
        end
    end

    assign busy              = (state == SETTLE);
    assign done              = (state == DONE);
    assign {in1, in2, in3}   = busy ? idx : '0;
    assign mismatch          = observed ^ exp_lat;

endmodule
